// File: rtl/fpu_bus_if.sv
// Host bus front end of the FPU: byte-wide operand/opcode registers, start/done
// handshake with the arithmetic core, result readback and command-end handshake.
module fpu_bus_if #(
   parameter int OP_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      databus_in,
   output logic [7:0]      databus_out,
   input  logic [3:0]      addr,
   input  logic            cs,
   input  logic            rd,
   input  logic            wr,
   input  logic            end_ack,
   output logic            cmd_end,
   output logic            busy,
   output logic [31:0]     op_a,
   output logic [31:0]     op_b,
   output logic [OP_W-1:0] operation,
   output logic            start,
   input  logic            core_done,
   input  logic [31:0]     core_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_wr_q;
   logic [31:0]       r_op_a;
   logic [31:0]       r_op_b;
   logic [OP_W-1:0]   r_operation;
   logic [31:0]       r_result;
   logic              r_overrun;
   logic              r_start;

   logic              w_commit;
   logic              w_start_cmd;
   logic              w_cfg_we;
   logic              w_launch;
   logic              w_latch_result;
   logic              w_overrun_set;

   // One commit per strobe: wr must have been sampled high on the previous edge.
   assign w_commit    = !cs && !wr && r_wr_q;
   assign w_start_cmd = w_commit && (addr == 4'h9);
   assign w_cfg_we    = w_commit && (r_state != S_RUN);

   // Sampled every edge, reset included, so a strobe spanning reset never commits twice.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register sees the pre-edge values of the others.
      r_wr_q <= wr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise the
      // paths that do not assign it would infer a latch.
      w_state_nxt    = r_state;
      w_launch       = 1'b0;
      w_latch_result = 1'b0;
      w_overrun_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_cmd) begin
               w_launch    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (core_done) begin
               w_latch_result = 1'b1;
               w_state_nxt    = S_DONE;
            end
            if (w_start_cmd) begin
               w_overrun_set = 1'b1;
            end
         end
         S_DONE: begin
            if (end_ack) begin
               w_state_nxt = S_IDLE;
            end
            if (w_start_cmd) begin
               w_overrun_set = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_operation <= '0;
         r_result    <= '0;
         r_overrun   <= 1'b0;
         r_start     <= 1'b0;
      end else begin
         r_start <= w_launch;

         if (w_launch) begin
            r_overrun <= 1'b0;
         end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end

         if (w_latch_result) begin
            r_result <= core_result;
         end

         // Operands are frozen while the core runs.
         if (w_cfg_we) begin
            case (addr)
               4'h0, 4'h1, 4'h2, 4'h3: r_op_a[{addr[1:0], 3'b000} +: 8] <= databus_in;
               4'h4, 4'h5, 4'h6, 4'h7: r_op_b[{addr[1:0], 3'b000} +: 8] <= databus_in;
               4'h8:                   r_operation <= databus_in[OP_W-1:0];
               default:                ;
            endcase
         end
      end
   end

   always_comb begin
      databus_out = 8'h00;
      if (!cs && !rd) begin
         case (addr)
            4'h9:    databus_out = r_result[7:0];
            4'hA:    databus_out = r_result[15:8];
            4'hB:    databus_out = r_result[23:16];
            4'hC:    databus_out = r_result[31:24];
            4'hD:    databus_out = {5'b00000, r_overrun, cmd_end, busy};
            default: databus_out = 8'h00;
         endcase
      end
   end

   assign op_a      = r_op_a;
   assign op_b      = r_op_b;
   assign operation = r_operation;
   assign start     = r_start;
   assign busy      = (r_state == S_RUN);
   assign cmd_end   = (r_state == S_DONE);

endmodule

// File: tb/tb_fpu_bus_if.sv
// Self-checking bench for fpu_bus_if: directed test-plan steps followed by random
// bus/core traffic, all compared every cycle against a command-level model.
module tb_fpu_bus_if;

   localparam int OP_W = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      databus_in;
   logic [7:0]      databus_out;
   logic [3:0]      addr;
   logic            cs, rd, wr, end_ack;
   logic            cmd_end, busy, start;
   logic [31:0]     op_a, op_b;
   logic [OP_W-1:0] operation;
   logic            core_done;
   logic [31:0]     core_result;

   int n_vec = 0;
   int n_err = 0;
   int n_starts = 0;

   // Reference model: command-level view of the block
   logic [31:0]     m_a, m_b, m_res;
   logic [OP_W-1:0] m_op;
   logic            m_ovr, m_executing, m_end, m_start;
   logic            m_wr_prev;

   fpu_bus_if #(.OP_W(OP_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .databus_in  (databus_in),
      .databus_out (databus_out),
      .addr        (addr),
      .cs          (cs),
      .rd          (rd),
      .wr          (wr),
      .end_ack     (end_ack),
      .cmd_end     (cmd_end),
      .busy        (busy),
      .op_a        (op_a),
      .op_b        (op_b),
      .operation   (operation),
      .start       (start),
      .core_done   (core_done),
      .core_result (core_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_read();
      logic [7:0] v;
      v = 8'h00;
      if (!cs && !rd) begin
         if (addr >= 4'h9 && addr <= 4'hC) v = m_res[8*(addr - 4'h9) +: 8];
         else if (addr == 4'hD)            v = {5'b0, m_ovr, m_end, m_executing};
      end
      return v;
   endfunction

   // One clock edge: update the model from the driven inputs, then compare.
   task automatic step();
      logic was_exec, was_end, commit;
      was_exec = m_executing;
      was_end  = m_end;
      commit   = !cs && !wr && m_wr_prev;
      m_wr_prev = wr;
      m_start  = 1'b0;
      if (!rst_n) begin
         m_a = '0; m_b = '0; m_op = '0; m_res = '0;
         m_ovr = 1'b0; m_executing = 1'b0; m_end = 1'b0;
      end else begin
         if (commit) begin
            if (addr <= 4'h3 && !was_exec)      m_a[8*addr +: 8] = databus_in;
            else if (addr <= 4'h7 && !was_exec) m_b[8*(addr - 4'h4) +: 8] = databus_in;
            else if (addr == 4'h8 && !was_exec) m_op = databus_in[OP_W-1:0];
            else if (addr == 4'h9) begin
               if (!was_exec && !was_end) begin
                  m_start = 1'b1; m_executing = 1'b1; m_ovr = 1'b0;
               end else begin
                  m_ovr = 1'b1;
               end
            end
         end
         if (core_done && was_exec) begin
            m_res = core_result; m_executing = 1'b0; m_end = 1'b1;
         end
         if (end_ack && was_end) m_end = 1'b0;
      end
      @(posedge clk);
      #1;
      if (start === 1'b1) n_starts++;
      check("op_a", op_a, m_a);
      check("op_b", op_b, m_b);
      check("operation", 32'(operation), 32'(m_op));
      check("start", 32'(start), 32'(m_start));
      check("busy", 32'(busy), 32'(m_executing));
      check("cmd_end", 32'(cmd_end), 32'(m_end));
      check("databus_out", 32'(databus_out), 32'(exp_read()));
   endtask

   task automatic bus_idle();
      cs = 1'b1; rd = 1'b1; wr = 1'b1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      cs = 1'b0; wr = 1'b0; addr = a; databus_in = d;
      step();
      bus_idle();
      step();
   endtask

   task automatic bus_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
      cs = 1'b0; rd = 1'b0; addr = a;
      #1;
      check(tag, 32'(databus_out), 32'(exp));
      bus_idle();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic core_finish(input logic [31:0] r);
      core_done = 1'b1; core_result = r;
      step();
      core_done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; bus_idle(); addr = 4'h0; databus_in = 8'h00;
      end_ack = 1'b0; core_done = 1'b0; core_result = 32'h0;
      m_wr_prev = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Byte writes and start
      bus_write(4'h0, 8'h0d); bus_write(4'h1, 8'h89);
      bus_write(4'h2, 8'h96); bus_write(4'h3, 8'h4d);
      bus_write(4'h4, 8'had); bus_write(4'h5, 8'h7f);
      bus_write(4'h6, 8'h44); bus_write(4'h7, 8'h4a);
      bus_write(4'h8, 8'h01);
      check("tp_op_a", op_a, 32'h4d96890d);
      check("tp_op_b", op_b, 32'h4a447fad);
      check("tp_operation", 32'(operation), 32'h01);
      n_starts = 0;
      cs = 1'b0; wr = 1'b0; addr = 4'h9;
      step();
      check("tp_busy", 32'(busy), 32'd1);
      bus_idle();
      step();
      check("tp_start_once", n_starts, 1);

      // Completion 5 cycles after start and readback
      idle_steps(3);
      core_finish(32'h4d98120c);
      check("tp_cmd_end", 32'(cmd_end), 32'd1);
      check("tp_busy_done", 32'(busy), 32'd0);
      bus_read("tp_res0", 4'h9, 8'h0c);
      bus_read("tp_res1", 4'hA, 8'h12);
      bus_read("tp_res2", 4'hB, 8'h98);
      bus_read("tp_res3", 4'hC, 8'h4d);
      bus_read("tp_status", 4'hD, 8'h02);
      bus_read("tp_unmapped", 4'h3, 8'h00);

      // Acknowledge
      end_ack = 1'b1; step(); end_ack = 1'b0;
      check("tp_ack", 32'(cmd_end), 32'd0);

      // end_ack held high before completion: one-cycle cmd_end
      bus_write(4'h9, 8'h00);
      end_ack = 1'b1;
      step();
      core_finish(32'h11223344);
      check("tp_held_ack_hi", 32'(cmd_end), 32'd1);
      step();
      check("tp_held_ack_lo", 32'(cmd_end), 32'd0);
      end_ack = 1'b0;

      // Guards: operand write and start during RUN, start in DONE
      bus_write(4'h9, 8'h00);
      n_starts = 0;
      bus_write(4'h0, 8'hFF);
      check("tp_guard_op_a", op_a, 32'h4d96890d);
      bus_write(4'h9, 8'h00);
      check("tp_guard_nostart", n_starts, 0);
      bus_read("tp_ovr_run", 4'hD, 8'h05);
      core_finish(32'hcafef00d);
      bus_write(4'h9, 8'h00);
      bus_read("tp_ovr_done", 4'hD, 8'h06);
      check("tp_guard_nostart2", n_starts, 0);
      end_ack = 1'b1; step(); end_ack = 1'b0;
      bus_write(4'h9, 8'h00);
      bus_read("tp_ovr_clr", 4'hD, 8'h01);
      core_finish(32'h0badc0de);
      end_ack = 1'b1; step(); end_ack = 1'b0;

      // wr held low for 4 cycles on 0x9
      n_starts = 0;
      cs = 1'b0; wr = 1'b0; addr = 4'h9;
      idle_steps(4);
      bus_idle();
      idle_steps(2);
      check("tp_long_wr", n_starts, 1);
      core_finish(32'h12345678);
      end_ack = 1'b1; step(); end_ack = 1'b0;

      // wr falling with cs=1, cs dropping later in the same strobe
      cs = 1'b1; wr = 1'b0; addr = 4'h0; databus_in = 8'h11;
      step();
      cs = 1'b0;
      step();
      bus_idle();
      step();
      check("tp_cs_high", op_a, 32'h4d96890d);

      // core_done in IDLE
      core_finish(32'hdeadbeef);
      check("tp_spur_end", 32'(cmd_end), 32'd0);
      bus_read("tp_spur_res", 4'h9, 8'h78);

      // Reset mid-command
      bus_write(4'h9, 8'h00);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      core_finish(32'h55aa55aa);
      check("tp_rst_busy", 32'(busy), 32'd0);
      check("tp_rst_end", 32'(cmd_end), 32'd0);
      check("tp_rst_op_a", op_a, 32'd0);
      bus_read("tp_rst_res", 4'h9, 8'h00);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         cs          = ($urandom_range(0, 3) == 0);
         wr          = ($urandom_range(0, 1) == 0);
         rd          = ($urandom_range(0, 1) == 0);
         addr        = 4'($urandom_range(0, 15));
         if (addr < 4'h9 && $urandom_range(0, 1) == 0) addr = 4'h9;
         databus_in  = 8'($urandom());
         core_done   = ($urandom_range(0, 5) == 0);
         core_result = $urandom();
         end_ack     = ($urandom_range(0, 3) == 0);
         step();
      end
      rst_n = 1'b1; bus_idle(); core_done = 1'b0; end_ack = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
